mips_idex_stage: RTL and testbench
==================================

Name: mips_idex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit MIPS ALU.
- Registers decoded operands, resolves the 4-bit ALU control from ALUOp/funct, applies EX/MEM and MEM/WB forwarding, and presents A, B and ALUCtl to the ALU.
- Single-entry valid/ready handshake on both sides; supports flush.

Parameters:
- DATA_W, 32, operand width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved.
- funct  in  6  R-type function code.
- rs_addr, rt_addr  in  5 each  source register numbers.
- rs_data, rt_data  in  32 each  register-file read data.
- rd_addr  in  5  destination register (0 = no writeback).
- use_imm  in  1  B comes from immediate instead of rt.
- imm  in  16  instruction immediate.
- exmem_wr, exmem_rd, exmem_data  in  1/5/32  EX/MEM forwarding source.
- memwb_wr, memwb_rd, memwb_data  in  1/5/32  MEM/WB forwarding source.
- flush  in  1  kill held entry and block capture this cycle.
- out_valid  out  1  A/B/alu_ctl valid toward the ALU.
- out_ready  in  1  EX stage consumes entry.
- alu_ctl  out  4  ALU control code.
- a, b  out  32 each  ALU operands.
- dest  out  5  registered rd_addr.

Behaviour:
- Reset (async, asserted): out_valid=0, alu_ctl=0, a=0, b=0, dest=0; illegal=0 when present. Reset mid-transfer discards the held entry.
- in_ready = !out_valid | out_ready (combinational). Capture when in_valid & in_ready & !flush; out_valid=1 on the next edge. Latency is 1 cycle.
- Stall: while out_valid & !out_ready, all outputs hold bit-stable. Forwarding is evaluated only at capture.
- Consume without new capture: out_valid->0 and data outputs hold their last values.
- Simultaneous consume and capture: new entry replaces the old one with no bubble.
- Flush: out_valid->0 on the next edge and no capture that cycle. Flush overrides in_valid and stall.
- ALU control decode:
  - alu_op 00 -> 2; 01 -> 6.
  - alu_op 10: funct 32->2, 34->6, 36->0, 37->1, 39->12, 42->7, any other -> 15.
  - alu_op 11 -> 15.
- Forwarding, per source operand:
  - If exmem_wr and exmem_rd==addr and addr!=0, use exmem_data.
  - Else if memwb_wr and memwb_rd==addr and addr!=0, use memwb_data.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- B select: use_imm=1 gives the immediate, zero-extended when the decoded alu_ctl is 0 or 1, sign-extended otherwise. use_imm=0 gives forwarded rt.
- A is always forwarded rs.

Optional Feature:
- Macro: MIPS_IDEX_ILLEGAL_TRAP_EN.
- Defined:
  - Extra output illegal (1 bit), registered alongside the entry; set when decoded alu_ctl==15.
  - An illegal entry is presented with alu_ctl=15, a=0, b=0, dest=0, so no writeback occurs.
  - illegal follows the same hold, flush and reset rules as the other outputs.
- Undefined:
  - No illegal port.
  - Illegal decodes pass through with alu_ctl=15 and normal operands and dest (the ALU yields 0).

Test Plan:
- Reset with rst=1 mid-stream -> out_valid=0, a=b=0, alu_ctl=0 immediately, without waiting for a clock edge.
- alu_op=10, funct=42, rs_data=5, rt_data=9, rd=3, out_ready=1 -> next cycle out_valid=1, alu_ctl=7, a=5, b=9, dest=3.
- Forwarding: rs=4, rt=4, exmem_wr=1/rd=4/data=0x11, memwb_wr=1/rd=4/data=0x22 -> a=b=0x11. Repeat with rs=rt=0 -> a=b=rs_data/rt_data.
- use_imm=1, imm=0xFFF0, alu_op=00 -> b=0xFFFFFFF0. Same imm with alu_op=10, funct=37 -> b=0x0000FFF0, alu_ctl=1.
- Stall: out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs unchanged. Then out_ready=1 -> new entry loaded next edge with no bubble.
- flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and input not captured. Illegal funct=0 with alu_op=10 -> alu_ctl=15; with MIPS_IDEX_ILLEGAL_TRAP_EN, illegal=1 and dest=0.

Source files
------------

// File: rtl/mips_idex_stage.sv
// mips_idex_stage: ID/EX pipeline register in front of the 32-bit MIPS ALU.
// It decodes the 4-bit ALU control from alu_op/funct and resolves EX/MEM and
// MEM/WB forwarding when an instruction is captured. It then holds A, B,
// alu_ctl and dest for the ALU behind a single-entry valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer keeps its payload stable while valid is high and ready
// is low. The payload is only meaningful while valid is high.
// in_ready = !out_valid | out_ready, so a consume and a new capture can happen
// on the same edge and no bubble is inserted. flush kills the held entry and
// also blocks capture on that edge.
//
// Optional build macro MIPS_IDEX_ILLEGAL_TRAP_EN adds an 'illegal' output.
// When it is defined, an illegal decode (alu_ctl 15) is presented with zeroed
// operands and dest 0, so that no writeback takes place.
module mips_idex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              use_imm,
    input  logic [15:0]       imm,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_ctl,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic [REG_AW-1:0] dest
);

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;
    localparam logic [3:0] CTL_NOR = 4'd12;
    localparam logic [3:0] CTL_BAD = 4'd15;

    logic              capture;
    logic              consume;
    logic [3:0]        ctl_dec;
    logic              ctl_bad;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [REG_AW-1:0] dest_nxt;

    // Handshake qualifiers: flush always wins over a capture.
    always_comb begin
        in_ready = !out_valid || out_ready;
        capture  = in_valid && in_ready && !flush;
        consume  = out_valid && out_ready;
    end

    // ALU control decode from alu_op and funct.
    always_comb begin
        ctl_dec = CTL_BAD;
        case (alu_op)
            2'b00: ctl_dec = CTL_ADD;
            2'b01: ctl_dec = CTL_SUB;
            2'b10: begin
                case (funct)
                    6'd32:   ctl_dec = CTL_ADD;
                    6'd34:   ctl_dec = CTL_SUB;
                    6'd36:   ctl_dec = CTL_AND;
                    6'd37:   ctl_dec = CTL_OR;
                    6'd39:   ctl_dec = CTL_NOR;
                    6'd42:   ctl_dec = CTL_SLT;
                    default: ctl_dec = CTL_BAD;
                endcase
            end
            default: ctl_dec = CTL_BAD;
        endcase
        ctl_bad = (ctl_dec == CTL_BAD);
    end

    // rs forwarding: EX/MEM beats MEM/WB, and register 0 is never forwarded.
    always_comb begin
        rs_fwd = rs_data;
        if (exmem_wr && (exmem_rd == rs_addr) && (rs_addr != '0))
            rs_fwd = exmem_data;
        else if (memwb_wr && (memwb_rd == rs_addr) && (rs_addr != '0))
            rs_fwd = memwb_data;
    end

    // rt forwarding, with the same priority rules as rs.
    always_comb begin
        rt_fwd = rt_data;
        if (exmem_wr && (exmem_rd == rt_addr) && (rt_addr != '0))
            rt_fwd = exmem_data;
        else if (memwb_wr && (memwb_rd == rt_addr) && (rt_addr != '0))
            rt_fwd = memwb_data;
    end

    // Immediate extension: logical ops (AND/OR) zero-extend, all others sign-extend.
    always_comb begin
        if ((ctl_dec == CTL_AND) || (ctl_dec == CTL_OR))
            imm_ext = {{(DATA_W-16){1'b0}}, imm};
        else
            imm_ext = {{(DATA_W-16){imm[15]}}, imm};
        b_sel = use_imm ? imm_ext : rt_fwd;
    end

    // Next-entry payload; illegal entries are neutralised when the trap is built in.
    always_comb begin
        a_nxt    = rs_fwd;
        b_nxt    = b_sel;
        dest_nxt = rd_addr;
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
        if (ctl_bad) begin
            a_nxt    = '0;
            b_nxt    = '0;
            dest_nxt = '0;
        end
`endif
    end

    // Valid flag: flush kills the entry, a capture loads it, a consume drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_valid <= 1'b0;
        else if (flush)
            out_valid <= 1'b0;
        else if (capture)
            out_valid <= 1'b1;
        else if (consume)
            out_valid <= 1'b0;
    end

    // Payload registers load only on capture, so they are bit-stable during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_ctl <= '0;
            a       <= '0;
            b       <= '0;
            dest    <= '0;
        end else if (capture) begin
            alu_ctl <= ctl_dec;
            a       <= a_nxt;
            b       <= b_nxt;
            dest    <= dest_nxt;
        end
    end

`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
    // Illegal flag travels with the entry and obeys the same load/hold rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal <= 1'b0;
        else if (capture)
            illegal <= ctl_bad;
    end
`endif

endmodule

// File: tb/tb_mips_idex_stage.sv
// Directed bench for mips_idex_stage. Expected values are hand-computed constants.
module tb_mips_idex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic        use_imm;
  logic [15:0] imm;
  logic        exmem_wr, memwb_wr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] a, b;
  logic [4:0]  dest;
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int passed = 0;
  int total  = 0;

  mips_idex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr),
    .use_imm(use_imm), .imm(imm),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b),
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .dest(dest)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // advance one edge, sample 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic ui, input logic [15:0] im);
    alu_op = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; use_imm = ui; imm = im;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
    drive(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_dest", {27'd0, dest}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;

    // slt R-type
    drive(2'b10, 6'd42, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 1'b0, 16'd0);
    in_valid = 1'b1;
    step();
    chk("slt_valid", {31'd0, out_valid}, 32'd1);
    chk("slt_ctl", {28'd0, alu_ctl}, 32'd7);
    chk("slt_a", a, 32'd5);
    chk("slt_b", b, 32'd9);
    chk("slt_dest", {27'd0, dest}, 32'd3);

    // EX/MEM wins over MEM/WB
    drive(2'b00, 6'd0, 5'd4, 5'd4, 5'd6, 32'hAA, 32'hBB, 1'b0, 16'd0);
    exmem_wr = 1'b1; exmem_rd = 5'd4; exmem_data = 32'h11;
    memwb_wr = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h22;
    step();
    chk("fwd_ex_a", a, 32'h11);
    chk("fwd_ex_b", b, 32'h11);
    chk("fwd_ex_ctl", {28'd0, alu_ctl}, 32'd2);

    // MEM/WB only
    exmem_wr = 1'b0;
    step();
    chk("fwd_wb_a", a, 32'h22);
    chk("fwd_wb_b", b, 32'h22);

    // register 0 never forwarded
    drive(2'b01, 6'd0, 5'd0, 5'd0, 5'd6, 32'h5, 32'h6, 1'b0, 16'd0);
    exmem_wr = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    chk("r0_a", a, 32'h5);
    chk("r0_b", b, 32'h6);
    chk("r0_ctl", {28'd0, alu_ctl}, 32'd6);
    exmem_wr = 1'b0; memwb_wr = 1'b0;

    // immediate sign/zero extension
    drive(2'b00, 6'd0, 5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 1'b1, 16'hFFF0);
    step();
    chk("imm_sext_b", b, 32'hFFFF_FFF0);
    drive(2'b10, 6'd37, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 1'b1, 16'hFFF0);
    step();
    chk("imm_zext_b", b, 32'h0000_FFF0);
    chk("imm_zext_ctl", {28'd0, alu_ctl}, 32'd1);
    chk("imm_zext_dest", {27'd0, dest}, 32'd9);

    // stall three cycles with a new offer pending
    out_ready = 1'b0;
    drive(2'b10, 6'd34, 5'd10, 5'd11, 5'd7, 32'h100, 32'h200, 1'b0, 16'd0);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_ctl", {28'd0, alu_ctl}, 32'd1);
      chk("stall_b", b, 32'h0000_FFF0);
      chk("stall_dest", {27'd0, dest}, 32'd9);
    end
    out_ready = 1'b1;
    step();
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);
    chk("unstall_ctl", {28'd0, alu_ctl}, 32'd6);
    chk("unstall_a", a, 32'h100);
    chk("unstall_b", b, 32'h200);
    chk("unstall_dest", {27'd0, dest}, 32'd7);

    // flush beats a pending offer and a stall
    out_ready = 1'b0; flush = 1'b1;
    drive(2'b10, 6'd36, 5'd1, 5'd2, 5'd12, 32'h3, 32'h4, 1'b0, 16'd0);
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ctl_held", {28'd0, alu_ctl}, 32'd6);
    chk("flush_a_held", a, 32'h100);
    flush = 1'b0;

    // capture nor, then consume with no new offer
    drive(2'b10, 6'd39, 5'd1, 5'd2, 5'd13, 32'h7, 32'h8, 1'b0, 16'd0);
    step();
    chk("nor_ctl", {28'd0, alu_ctl}, 32'd12);
    chk("nor_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_ctl_held", {28'd0, alu_ctl}, 32'd12);
    chk("drain_dest_held", {27'd0, dest}, 32'd13);

    // sign extension for slt immediate, zero extension for and
    in_valid = 1'b1;
    drive(2'b10, 6'd42, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2, 1'b1, 16'h8000);
    step();
    chk("slti_b", b, 32'hFFFF_8000);
    drive(2'b10, 6'd36, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2, 1'b1, 16'h8000);
    step();
    chk("andi_b", b, 32'h0000_8000);
    chk("andi_ctl", {28'd0, alu_ctl}, 32'd0);

    // illegal funct under R-type, then reserved alu_op
    drive(2'b10, 6'd0, 5'd1, 5'd2, 5'd5, 32'h3, 32'h4, 1'b0, 16'd0);
    step();
    chk("ill_ctl", {28'd0, alu_ctl}, 32'd15);
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_dest", {27'd0, dest}, 32'd0);
    chk("ill_a", a, 32'd0);
    chk("ill_b", b, 32'd0);
`else
    chk("ill_dest", {27'd0, dest}, 32'd5);
    chk("ill_a", a, 32'h3);
    chk("ill_b", b, 32'h4);
`endif
    drive(2'b11, 6'd32, 5'd1, 5'd2, 5'd6, 32'h3, 32'h4, 1'b0, 16'd0);
    step();
    chk("rsv_ctl", {28'd0, alu_ctl}, 32'd15);

    // async reset mid-stream with an entry held
    out_ready = 1'b0;
    drive(2'b10, 6'd32, 5'd1, 5'd2, 5'd6, 32'h9, 32'hA, 1'b0, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_a", a, 32'd0);
    chk("arst_b", b, 32'd0);
    chk("arst_ctl", {28'd0, alu_ctl}, 32'd0);
    chk("arst_dest", {27'd0, dest}, 32'd0);
`ifdef MIPS_IDEX_ILLEGAL_TRAP_EN
    chk("arst_illegal", {31'd0, illegal}, 32'd0);
`endif
    in_valid = 1'b0;
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
